// File: rtl/inst_queue.sv
// inst_queue: show-ahead instruction FIFO between fetch and decode/issue.
// Fetch pushes {inst, pc, bp}; decode sees the head entry combinationally
// and pops it with iq_re_i. A ROB clear flushes all entries.
// Optional feature: define IQ_BYPASS_EN to let a push into an empty queue
// reach the decode outputs in the same cycle (zero-latency bypass).
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_we_i,
  input  logic [31:0]       if_inst_i,
  input  logic [31:0]       if_pc_i,
  input  logic              if_bp_i,
  output logic              iq_full_o,
  input  logic              iq_re_i,
  output logic              iq_empty_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              bp_o,
  output logic [ADDR_W:0]   count_o
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bp;
  } entry_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic full;
  logic stored_empty;
  logic bypass;
  logic push_ok;
  logic pop_ok;

  assign full         = (count == FULL_CNT);
  assign stored_empty = (count == '0);

`ifdef IQ_BYPASS_EN
  // A push into an empty queue is visible to decode in the same cycle.
  assign bypass = stored_empty && if_we_i && rdy && !clear;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode consumes immediately is never stored.
  assign push_ok = if_we_i && !full && rdy && !clear && !(bypass && iq_re_i);
  assign pop_ok  = iq_re_i && !stored_empty && rdy && !clear;

  // Entry storage: written at tail on an accepted push.
  // NOTE: the entry RAM has no reset; every read is qualified by count, so
  // stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[tail] <= '{inst: if_inst_i, pc: if_pc_i, bp: if_bp_i};
    end
  end

  // Head/tail pointers and occupancy; rdy low freezes everything.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_ok) tail <= tail + PTR_ONE;
        if (pop_ok)  head <= head + PTR_ONE;
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Head presentation: stored head entry, bypassed fetch word, or zeros.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    iq_empty_o = stored_empty;
    inst_o     = '0;
    pc_o       = '0;
    bp_o       = 1'b0;
    if (!stored_empty) begin
      inst_o = mem[head].inst;
      pc_o   = mem[head].pc;
      bp_o   = mem[head].bp;
    end
`ifdef IQ_BYPASS_EN
    if (bypass) begin
      iq_empty_o = 1'b0;
      inst_o     = if_inst_i;
      pc_o       = if_pc_i;
      bp_o       = if_bp_i;
    end
`endif
  end

  assign iq_full_o = full;
  assign count_o   = count;

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed stimulus with a scoreboard of expected head
// entries. Stimulus pushes expected entries; a negedge monitor pops and
// compares whenever the DUT accepts a pop.
module tb_inst_queue;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bp;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              rdy;
  logic              clear;
  logic              if_we_i;
  logic [31:0]       if_inst_i;
  logic [31:0]       if_pc_i;
  logic              if_bp_i;
  logic              iq_full_o;
  logic              iq_re_i;
  logic              iq_empty_o;
  logic [31:0]       inst_o;
  logic [31:0]       pc_o;
  logic              bp_o;
  logic [ADDR_W:0]   count_o;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];

  // Pending-cycle bookkeeping shared between drive() and tick().
  bit   p_we, p_clr, p_r, p_byp;
  int   p_pre;
  exp_t p_e;

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .clear      (clear),
    .if_we_i    (if_we_i),
    .if_inst_i  (if_inst_i),
    .if_pc_i    (if_pc_i),
    .if_bp_i    (if_bp_i),
    .iq_full_o  (iq_full_o),
    .iq_re_i    (iq_re_i),
    .iq_empty_o (iq_empty_o),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .bp_o       (bp_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for the coming edge and note what the scoreboard expects.
  task automatic drive(input bit we, input logic [31:0] inst, input logic [31:0] pc,
                       input bit bp, input bit re, input bit clr, input bit r);
    if_we_i   = we;
    if_inst_i = inst;
    if_pc_i   = pc;
    if_bp_i   = bp;
    iq_re_i   = re;
    clear     = clr;
    rdy       = r;
    p_we  = we;
    p_clr = clr;
    p_r   = r;
    p_pre = sb.size();
    p_e   = '{inst: inst, pc: pc, bp: bp};
    p_byp = 1'b0;
`ifdef IQ_BYPASS_EN
    if (p_pre == 0 && we && r && !clr) begin
      sb.push_back(p_e);
      p_byp = 1'b1;
    end
`endif
  endtask

  // Clock edge; update expected contents, then settle past the edge.
  task automatic tick();
    @(posedge clk);
    if (p_r) begin
      if (p_clr) sb.delete();
      else if (p_we && p_pre < DEPTH && !p_byp) sb.push_back(p_e);
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && rdy && !clear && iq_re_i && !iq_empty_o) begin
      if (sb.size() == 0) begin
        check("pop_without_expected_entry", 64'(pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("pop_pc",   64'(pc_o),   64'(sb[0].pc));
        check("pop_inst", 64'(inst_o), 64'(sb[0].inst));
        check("pop_bp",   64'(bp_o),   64'(sb[0].bp));
        void'(sb.pop_front());
      end
    end
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    idle();
    #1 rst_n = 1'b0;
    #2;
    check("reset_empty", 64'(iq_empty_o), 64'd1);
    check("reset_full",  64'(iq_full_o),  64'd0);
    check("reset_count", 64'(count_o),    64'd0);
    check("reset_inst",  64'(inst_o),     64'd0);
    check("reset_pc",    64'(pc_o),       64'd0);
    check("reset_bp",    64'(bp_o),       64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single push, visible the cycle after.
    drive(1'b1, 32'h0000_0513, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("single_empty", 64'(iq_empty_o), 64'd0);
    check("single_inst",  64'(inst_o),     64'h513);
    check("single_pc",    64'(pc_o),       64'h0);
    check("single_count", 64'(count_o),    64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("single_drained", 64'(iq_empty_o), 64'd1);

    // Fill to DEPTH, drop a 17th, then push+pop while full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h1000 + i, i * 4, i[0], 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("fill_full",  64'(iq_full_o), 64'd1);
    check("fill_count", 64'(count_o),   64'd16);
    drive(1'b1, 32'h2000, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("drop_count", 64'(count_o), 64'd16);
    check("drop_head",  64'(pc_o),    64'h0);
    drive(1'b1, 32'h2000, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("full_pushpop_count", 64'(count_o),   64'd15);
    check("full_pushpop_full",  64'(iq_full_o), 64'd0);
    check("full_pushpop_head",  64'(pc_o),      64'h4);
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    check("drain_empty", 64'(iq_empty_o), 64'd1);
    check("drain_count", 64'(count_o),    64'd0);
    check("drain_pc",    64'(pc_o),       64'd0);

    // Steady state at count 5 across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h1000 + i * 4, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    for (int i = 5; i < 25; i++) begin
      drive(1'b1, 32'h3000 + i, 32'h1000 + i * 4, i[1], 1'b1, 1'b0, 1'b1);
      tick();
      check("steady_count", 64'(count_o), 64'd5);
    end
    check("steady_head", 64'(pc_o), 64'h1000 + 64'd20 * 4);

    // Clear at count 7 with push and pop in the same cycle.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h4000 + i, 32'h2000 + i * 4, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("pre_clear_count", 64'(count_o), 64'd7);
    drive(1'b1, 32'h5000, 32'h5000, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("clear_count", 64'(count_o),    64'd0);
    check("clear_empty", 64'(iq_empty_o), 64'd1);
    check("clear_inst",  64'(inst_o),     64'd0);
    check("clear_pc",    64'(pc_o),       64'd0);
    check("clear_bp",    64'(bp_o),       64'd0);
    drive(1'b1, 32'h0000_0013, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check("after_clear_pc",   64'(pc_o),   64'h100);
    check("after_clear_inst", 64'(inst_o), 64'h13);
    check("after_clear_bp",   64'(bp_o),   64'd1);

    // rdy low freezes state even with push, pop and clear requested.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h6000 + i, 32'h104 + i * 4, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h7000, 32'h7000, 1'b0, 1'b1, (i == 2), 1'b0);
      tick();
      check("stall_count", 64'(count_o), 64'd3);
      check("stall_head",  64'(pc_o),    64'h100);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    check("unstall_head",  64'(pc_o),    64'h104);
    check("unstall_count", 64'(count_o), 64'd2);

    // Asynchronous reset between edges empties the queue at once.
    idle();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_count", 64'(count_o),    64'd0);
    check("async_rst_empty", 64'(iq_empty_o), 64'd1);
    check("async_rst_pc",    64'(pc_o),       64'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Push into an empty queue with decode already requesting.
    drive(1'b1, 32'h0000_0093, 32'h200, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
`ifdef IQ_BYPASS_EN
    check("bypass_pc",    64'(pc_o),       64'h200);
    check("bypass_empty", 64'(iq_empty_o), 64'd0);
    tick();
    check("bypass_count", 64'(count_o), 64'd0);
`else
    check("nobypass_pc",    64'(pc_o),       64'h0);
    check("nobypass_empty", 64'(iq_empty_o), 64'd1);
    tick();
    check("nobypass_count", 64'(count_o), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
`endif
    idle();
    tick();
    check("final_count", 64'(count_o),    64'd0);
    check("final_empty", 64'(iq_empty_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
